adder_3_bit: RTL and testbench
==============================

ADDER_3_BIT -- requirements
Module: adder_3_bit

Interface
REQ-001 Parameter: OUT_REG, default 0, selects output timing; 0 = combinational outputs, 1 = outputs registered on clk.
REQ-002 Port: clk  input  1  single system clock, rising-edge active; used only when OUT_REG=1.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low; used only when OUT_REG=1.
REQ-004 Port: A1  input  1  operand A bit 0 (LSB).
REQ-005 Port: A2  input  1  operand A bit 1.
REQ-006 Port: A3  input  1  operand A bit 2 (MSB).
REQ-007 Port: B1  input  1  operand B bit 0 (LSB).
REQ-008 Port: B2  input  1  operand B bit 1.
REQ-009 Port: B3  input  1  operand B bit 2 (MSB).
REQ-010 Port: Cin  input  1  carry-in, weight 1.
REQ-011 Port: S  output  1  sum bit 0 (LSB).
REQ-012 Port: S2  output  1  sum bit 1.
REQ-013 Port: S3  output  1  sum bit 2.
REQ-014 Port: Cout  output  1  carry-out, sum bit 3.

Function
REQ-015 The block SHALL compute {Cout,S3,S2,S} = {A3,A2,A1} + {B3,B2,B1} + Cin as an unsigned 4-bit result, range 0..15.
REQ-016 The adder SHALL be a ripple-carry chain of three full-adder stages; stage i: sum = a ^ b ^ c, carry = (a & b) | (c & (a ^ b)); stage-0 carry-in = Cin, stage-2 carry-out = Cout.
REQ-017 Arithmetic SHALL be exact for all 128 input combinations; no overflow exists because Cout holds the 4th bit.
REQ-018 With OUT_REG=0 the outputs SHALL be purely combinational, settle within 5 ns of any input change, contain no storage, and ignore clk and rst_n.
REQ-019 With OUT_REG=1 the combinational result SHALL be captured into a 4-bit register on each rising clk edge; outputs reflect inputs present at the previous edge (latency 1 cycle).
REQ-020 With OUT_REG=1 there SHALL be no enable or handshake; every clock edge loads a new result.
REQ-021 X/Z on any input SHALL NOT be masked; outputs follow standard gate semantics.

Reset
REQ-022 With OUT_REG=1, rst_n=0 SHALL asynchronously force S, S2, S3, Cout to 0 without waiting for a clk edge.
REQ-023 While rst_n=0 the registers SHALL hold 0 regardless of clk and inputs.
REQ-024 On rst_n rising, the first rising clk edge with rst_n=1 SHALL load the current sum; reset asserted mid-stream SHALL discard the in-flight result.
REQ-025 With OUT_REG=0 rst_n SHALL have no effect on outputs.

Verification
REQ-026 OUT_REG=0: A=000, B=000, Cin=0 -> Cout,S3,S2,S = 0,0,0,0; Cin=1 -> 0,0,0,1.
REQ-027 OUT_REG=0: A=101 (5), B=011 (3), Cin=1 -> 9: Cout=1, S3=0, S2=0, S=1.
REQ-028 OUT_REG=0: A=111, B=111, Cin=1 -> 15: Cout=1, S3=1, S2=1, S=1; A=100, B=100, Cin=0 -> 8: Cout=1, others 0.
REQ-029 OUT_REG=0: exhaustive sweep of {A3,A2,A1,B3,B2,B1,Cin} = 0..127, 5 ns per vector; each output equals the arithmetic sum of REQ-015.
REQ-030 OUT_REG=1: drive A=011, B=010, Cin=0 -> outputs 0 before the edge, 0101 after the first rising clk; changing inputs between edges does not change outputs.
REQ-031 OUT_REG=1: with outputs at 1111, pull rst_n low between clock edges -> outputs 0000 immediately; release -> sum appears on the next rising edge.

Source files
------------

// File: rtl/adder_3_bit.sv
// 3-bit ripple-carry adder with carry-in/out; OUT_REG selects combinational
// or single-register output timing.
module adder_3_bit_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module adder_3_bit #(
  parameter bit OUT_REG = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic Cin,
  output logic S,
  output logic S2,
  output logic S3,
  output logic Cout
);
  logic [2:0] a, b, sum;
  logic       carry [4];
  logic [3:0] res_d;

  assign a        = {A3, A2, A1};
  assign b        = {B3, B2, B1};
  assign carry[0] = Cin;

  for (genvar i = 0; i < 3; i++) begin : g_stage
    adder_3_bit_fa u_fa (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (carry[i]),
      .s_o (sum[i]),
      .c_o (carry[i+1])
    );
  end

  assign res_d = {carry[3], sum};

  if (OUT_REG) begin : g_reg
    logic [3:0] res_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) res_q <= '0;
      else        res_q <= res_d;
    end
    assign {Cout, S3, S2, S} = res_q;
  end else begin : g_comb
    // clk/rst_n are part of the fixed interface but have no role here.
    logic unused_clk_rst;
    assign unused_clk_rst    = clk ^ rst_n;
    assign {Cout, S3, S2, S} = res_d;
  end
endmodule

// File: tb/tb_adder_3_bit.sv
// Bench: combinational and registered instances share operands; a sum model
// is checked every falling edge, with literal vectors pinning the model.
module tb_adder_3_bit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       s0, s20, s30, c0;
  logic       s1, s21, s31, c1;
  logic [3:0] out0, out1;
  logic [3:0] exp_reg = '0;
  int         n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  adder_3_bit #(.OUT_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .A1(a[0]), .A2(a[1]), .A3(a[2]),
    .B1(b[0]), .B2(b[1]), .B3(b[2]), .Cin(cin),
    .S(s0), .S2(s20), .S3(s30), .Cout(c0)
  );

  adder_3_bit #(.OUT_REG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .A1(a[0]), .A2(a[1]), .A3(a[2]),
    .B1(b[0]), .B2(b[1]), .B3(b[2]), .Cin(cin),
    .S(s1), .S2(s21), .S3(s31), .Cout(c1)
  );

  assign out0 = {c0, s30, s20, s0};
  assign out1 = {c1, s31, s21, s1};

  function automatic logic [3:0] arith(input logic [2:0] x, input logic [2:0] y,
                                       input logic ci);
    return {1'b0, x} + {1'b0, y} + {3'b000, ci};
  endfunction

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, got, exp);
  endtask

  // Registered output = arithmetic sum of operands seen at the last edge,
  // cleared immediately by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_reg <= 4'd0;
    else        exp_reg <= arith(a, b, cin);
  end

  always @(negedge clk) begin
    check("comb_model", out0, arith(a, b, cin));
    check("reg_model", out1, exp_reg);
  end

  task automatic drive(input logic [2:0] x, input logic [2:0] y, input logic ci);
    a = x; b = y; cin = ci;
  endtask

  initial begin
    logic [6:0] v;
    #2;
    check("reset_state", out1, 4'b0000);
    drive(3'b111, 3'b111, 1'b1);
    @(posedge clk); #2;
    check("reset_hold", out1, 4'b0000);
    check("comb_in_reset", out0, 4'b1111);

    @(negedge clk); #1 drive(3'b000, 3'b000, 1'b0); #2;
    check("zero", out0, 4'b0000);
    @(negedge clk); #1 drive(3'b000, 3'b000, 1'b1); #2;
    check("cin_only", out0, 4'b0001);
    @(negedge clk); #1 drive(3'b101, 3'b011, 1'b1); #2;
    check("5p3p1", out0, 4'b1001);
    @(negedge clk); #1 drive(3'b111, 3'b111, 1'b1); #2;
    check("max", out0, 4'b1111);
    @(negedge clk); #1 drive(3'b100, 3'b100, 1'b0); #2;
    check("4p4", out0, 4'b1000);

    // registered: reset release, one-cycle latency, hold between edges
    @(negedge clk); #1 rst_n = 1'b1; drive(3'b011, 3'b010, 1'b0); #2;
    check("reg_pre_edge", out1, 4'b0000);
    @(posedge clk); #1;
    check("reg_post_edge", out1, 4'b0101);
    drive(3'b000, 3'b001, 1'b1); #2;
    check("reg_hold", out1, 4'b0101);

    // async reset between edges, then reload
    @(negedge clk); #1 drive(3'b111, 3'b111, 1'b1);
    @(posedge clk); #1;
    check("reg_full", out1, 4'b1111);
    #1 rst_n = 1'b0; #1;
    check("reg_async_rst", out1, 4'b0000);
    check("comb_ignores_rst", out0, 4'b1111);
    #1 rst_n = 1'b1; #1;
    check("reg_after_release", out1, 4'b0000);
    @(posedge clk); #1;
    check("reg_reload", out1, 4'b1111);

    // exhaustive sweep, 5 ns per vector
    @(negedge clk); #1;
    for (int i = 0; i < 128; i++) begin
      v = 7'(i);
      drive(v[6:4], v[3:1], v[0]);
      #2 check("sweep", out0, arith(v[6:4], v[3:1], v[0]));
      #3;
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
